reg_window_mgr: RTL and testbench

- Multi-channel manager for memory-backed registers. Each process's register file lives in memory at base_addr + regnum.
- NCH requesters (ALU operand/result ports, IP updater) issue read, pointer-read, write or pointer-write requests. The block serialises them onto one memory bus with round-robin fairness.
- Pointer ops read the register first and optionally write it back with post-increment/decrement by a configurable step.
- Sits between the instruction sequencer and the shared memory bus arbiter.

---
 rtl/reg_window_mgr_if.sv | 39 +++
 rtl/reg_window_mgr.sv | 250 +++++++++++++++++++++++++
 tb/tb_reg_window_mgr.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_window_mgr_if.sv
// Bundle of request/response and memory-bus signals for the register window manager.
// The manager uses the slave view; the requesters/memory side uses the master view.
interface reg_window_mgr_if #(
    parameter int NCH    = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REGN_W = 4
);
    logic [ADDR_W-1:0]       base_addr;
    logic [NCH-1:0]          req_valid;
    logic [2*NCH-1:0]        req_op;
    logic [REGN_W*NCH-1:0]   req_reg;
    logic [2*NCH-1:0]        req_flags;
    logic [DATA_W*NCH-1:0]   req_data;
    logic [NCH-1:0]          req_ready;
    logic [NCH-1:0]          rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic [DATA_W-1:0]       rsp_ptr;
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_ack;
    logic [DATA_W-1:0]       mem_rdata;

    modport slave (
        input  base_addr, req_valid, req_op, req_reg, req_flags, req_data,
        input  mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_ptr,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output base_addr, req_valid, req_op, req_reg, req_flags, req_data,
        output mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_ptr,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/reg_window_mgr.sv
// Register window manager: serialises register read/write and pointer
// (indirect) requests from several channels onto one memory bus, with
// round-robin fairness and optional post-increment/decrement of pointers.
module reg_window_mgr #(
    parameter int NCH    = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REGN_W = 4,
    parameter int STEP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    reg_window_mgr_if.slave   bus
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_READ_P  = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_REG,
        RD_IND,
        WR_IND,
        WR_REG,
        WB_PTR,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CH_W-1:0]   last_q;
    logic [CH_W-1:0]   grant_q;
    logic [CH_W-1:0]   grant;
    logic              found;
    logic              accept;

    logic [1:0]        op_q;
    logic [REGN_W-1:0] reg_q;
    logic [1:0]        flags_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] base_q;

    logic [1:0]        sel_op;
    logic [REGN_W-1:0] sel_reg;
    logic [1:0]        sel_flags;
    logic [DATA_W-1:0] sel_data;

    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] rsp_ptr_q;
    logic [NCH-1:0]    ready;
    logic [NCH-1:0]    rsp_valid;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              mem_done;
    logic              do_wb;
    logic [ADDR_W-1:0] reg_addr;
    logic [ADDR_W-1:0] ind_addr;
    logic [DATA_W-1:0] ptr_next;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_wdata;

    assign sel_op    = bus.req_op[2*grant +: 2];
    assign sel_reg   = bus.req_reg[REGN_W*grant +: REGN_W];
    assign sel_flags = bus.req_flags[2*grant +: 2];
    assign sel_data  = bus.req_data[DATA_W*grant +: DATA_W];

    assign accept   = (state_q == IDLE) && found && !rst;
    assign mem_done = mem_req_q && bus.mem_ack;
    assign do_wb    = (flags_q == 2'b01) || (flags_q == 2'b10);
    assign reg_addr = base_q + ADDR_W'(reg_q);
    assign ind_addr = base_q + ADDR_W'(rsp_ptr_q);
    assign ptr_next = (flags_q == 2'b01) ? (rsp_ptr_q + DATA_W'(STEP))
                                         : (rsp_ptr_q - DATA_W'(STEP));

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_ptr   = rsp_ptr_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Round-robin search: first requesting channel after the last one served.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last_q) + i) % NCH;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = CH_W'(idx);
            end
        end
    end

    // One-hot accept strobe and completion pulse for the channel being served.
    always_comb begin
        ready     = '0;
        rsp_valid = '0;
        if (accept) begin
            ready[grant] = 1'b1;
        end
        if (state_q == RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
    end

    // Bus command for the current memory state, latched when the state issues it.
    always_comb begin
        issue_we    = 1'b0;
        issue_addr  = reg_addr;
        issue_wdata = data_q;
        case (state_q)
            RD_IND: begin
                issue_addr = ind_addr;
            end
            WR_IND: begin
                issue_we   = 1'b1;
                issue_addr = ind_addr;
            end
            WR_REG: begin
                issue_we = 1'b1;
            end
            WB_PTR: begin
                issue_we    = 1'b1;
                issue_wdata = ptr_next;
            end
            default: begin
                issue_we = 1'b0;
            end
        endcase
    end

    // Sequencing: each memory state advances only on the ack of its own request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (sel_op == OP_WRITE) ? WR_REG : RD_REG;
                end
            end
            RD_REG: begin
                if (mem_done) begin
                    if (op_q == OP_READ) begin
                        state_d = RESP;
                    end else if (op_q == OP_READ_P) begin
                        state_d = RD_IND;
                    end else begin
                        state_d = WR_IND;
                    end
                end
            end
            RD_IND, WR_IND: begin
                if (mem_done) begin
                    state_d = do_wb ? WB_PTR : RESP;
                end
            end
            WR_REG, WB_PTR: begin
                if (mem_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, registered bus outputs and result collection.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= CH_W'(NCH - 1);
            grant_q     <= '0;
            op_q        <= '0;
            reg_q       <= '0;
            flags_q     <= '0;
            data_q      <= '0;
            base_q      <= '0;
            rsp_data_q  <= '0;
            rsp_ptr_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_q     <= grant;
                        grant_q    <= grant;
                        op_q       <= sel_op;
                        reg_q      <= sel_reg;
                        flags_q    <= sel_flags;
                        data_q     <= sel_data;
                        base_q     <= bus.base_addr;
                        rsp_ptr_q  <= '0;
                        rsp_data_q <= sel_op[1] ? sel_data : '0;
                    end
                end
                RESP: begin
                    mem_req_q <= 1'b0;
                end
                default: begin
                    if (!mem_req_q) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= issue_we;
                        mem_addr_q  <= issue_addr;
                        mem_wdata_q <= issue_wdata;
                    end else if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (state_q == RD_REG) begin
                            rsp_ptr_q <= bus.mem_rdata;
                            if (op_q == OP_READ) begin
                                rsp_data_q <= bus.mem_rdata;
                            end
                        end else if (state_q == RD_IND) begin
                            rsp_data_q <= bus.mem_rdata;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_window_mgr.sv
// Directed bench for reg_window_mgr: a behavioural memory with programmable
// ack delay, a bus-stability monitor, and hand-computed expected results.
module tb_reg_window_mgr;

    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_window_mgr_if #(.NCH(NCH), .DATA_W(32), .ADDR_W(32), .REGN_W(4)) bus ();

    reg_window_mgr #(
        .NCH(NCH), .DATA_W(32), .ADDR_W(32), .REGN_W(4), .STEP(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [logic [31:0]];
    logic        log_we    [$];
    logic [31:0] log_addr  [$];
    logic [31:0] log_wdata [$];

    int   ack_delay    = 0;
    logic stray_ack    = 1'b0;
    int   unstable_cnt = 0;
    int   checks_total = 0;
    int   checks_passed = 0;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expectAccess(input string tag, input int idx, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
        if (log_addr.size() > idx) begin
            checkOutput({tag, " we"}, log_we[idx], we);
            checkOutput({tag, " addr"}, log_addr[idx], addr);
            if (we) checkOutput({tag, " wdata"}, log_wdata[idx], wdata);
        end else begin
            checkOutput({tag, " missing"}, log_addr.size(), idx + 1);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [1:0] op, input logic [3:0] rg,
                                 input logic [1:0] fl, input logic [31:0] data,
                                 input logic [31:0] base, output int lat,
                                 output logic [31:0] rdata, output logic [31:0] rptr);
        int n;
        logic [NCH-1:0] exp_v;
        log_we.delete();
        log_addr.delete();
        log_wdata.delete();
        @(negedge clk);
        bus.req_op[2*ch +: 2]     = op;
        bus.req_reg[4*ch +: 4]    = rg;
        bus.req_flags[2*ch +: 2]  = fl;
        bus.req_data[32*ch +: 32] = data;
        bus.base_addr             = base;
        bus.req_valid[ch]         = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[ch] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("accept seen", n < 50, 1'b1);
        @(negedge clk);
        bus.req_valid[ch] = 1'b0;
        lat = 1;
        while (bus.rsp_valid == '0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        exp_v = '0;
        exp_v[ch] = 1'b1;
        checkOutput("rsp_valid onehot", bus.rsp_valid, exp_v);
        rdata = bus.rsp_data;
        rptr  = bus.rsp_ptr;
    endtask

    // Behavioural memory: acks after ack_delay cycles of a held request.
    initial begin
        int wait_cnt;
        wait_cnt      = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (stray_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hBAD0BAD0;
                wait_cnt      = 0;
            end else if (!rst && bus.mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = memRead(bus.mem_addr);
                    log_we.push_back(bus.mem_we);
                    log_addr.push_back(bus.mem_addr);
                    log_wdata.push_back(bus.mem_wdata);
                    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Bus monitor: a pending request must hold its command; it must drop after ack.
    initial begin
        logic p_req, p_ack, p_we, p_rst;
        logic [31:0] p_addr, p_wdata;
        p_req = 0; p_ack = 0; p_we = 0; p_rst = 1; p_addr = 0; p_wdata = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !p_rst) begin
                if (p_req && !p_ack &&
                    (!bus.mem_req || bus.mem_addr !== p_addr ||
                     bus.mem_we !== p_we || bus.mem_wdata !== p_wdata))
                    unstable_cnt++;
                if (p_req && p_ack && bus.mem_req)
                    unstable_cnt++;
            end
            p_req = bus.mem_req; p_ack = bus.mem_ack; p_we = bus.mem_we;
            p_addr = bus.mem_addr; p_wdata = bus.mem_wdata; p_rst = rst;
        end
    end

    // Main directed sequence.
    initial begin
        int lat;
        int n;
        int acc;
        int bad;
        int order [5];
        logic [31:0] rd, rp;

        bus.base_addr = '0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_reg   = '0;
        bus.req_flags = '0;
        bus.req_data  = '0;

        // Reset state, including a request held during reset.
        repeat (2) @(negedge clk);
        bus.req_valid[0] = 1'b1;
        #1;
        checkOutput("reset req_ready", bus.req_ready, 0);
        checkOutput("reset rsp_valid", bus.rsp_valid, 0);
        checkOutput("reset mem_req", bus.mem_req, 0);
        checkOutput("reset rsp_data", bus.rsp_data, 0);
        checkOutput("reset rsp_ptr", bus.rsp_ptr, 0);
        checkOutput("reset mem_addr", bus.mem_addr, 0);
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Plain READ, zero-wait.
        mem[32'h103] = 32'hDEAD;
        applyStimulus(0, 2'b00, 4'd3, 2'b00, 32'h0, 32'h100, lat, rd, rp);
        checkOutput("read latency", lat, 3);
        checkOutput("read data", rd, 32'hDEAD);
        checkOutput("read ptr", rp, 32'hDEAD);
        checkOutput("read access count", log_addr.size(), 1);
        expectAccess("read acc0", 0, 1'b0, 32'h103, 32'h0);

        // READ_P with post-increment.
        mem[32'h105] = 32'h20;
        mem[32'h120] = 32'h77;
        applyStimulus(1, 2'b01, 4'd5, 2'b01, 32'h0, 32'h100, lat, rd, rp);
        checkOutput("readp latency", lat, 7);
        checkOutput("readp data", rd, 32'h77);
        checkOutput("readp ptr", rp, 32'h20);
        checkOutput("readp access count", log_addr.size(), 3);
        expectAccess("readp acc0", 0, 1'b0, 32'h105, 32'h0);
        expectAccess("readp acc1", 1, 1'b0, 32'h120, 32'h0);
        expectAccess("readp acc2", 2, 1'b1, 32'h105, 32'h21);

        // WRITE_P with post-decrement wrapping 0 -> FFFFFFFF.
        mem[32'h102] = 32'h0;
        applyStimulus(2, 2'b11, 4'd2, 2'b10, 32'hAA, 32'h100, lat, rd, rp);
        checkOutput("writep latency", lat, 7);
        checkOutput("writep data", rd, 32'hAA);
        checkOutput("writep ptr", rp, 32'h0);
        expectAccess("writep acc0", 0, 1'b0, 32'h102, 32'h0);
        expectAccess("writep acc1", 1, 1'b1, 32'h100, 32'hAA);
        expectAccess("writep acc2", 2, 1'b1, 32'h102, 32'hFFFFFFFF);
        checkOutput("writep mem", memRead(32'h102), 32'hFFFFFFFF);

        // Plain WRITE.
        applyStimulus(3, 2'b10, 4'd7, 2'b00, 32'h1234, 32'h200, lat, rd, rp);
        checkOutput("write latency", lat, 3);
        checkOutput("write data", rd, 32'h1234);
        checkOutput("write ptr", rp, 32'h0);
        checkOutput("write access count", log_addr.size(), 1);
        expectAccess("write acc0", 0, 1'b1, 32'h207, 32'h1234);

        // READ_P with flags 11: no write-back.
        mem[32'h10B] = 32'h30;
        mem[32'h130] = 32'h44;
        applyStimulus(1, 2'b01, 4'd11, 2'b11, 32'h0, 32'h100, lat, rd, rp);
        checkOutput("readp nowb latency", lat, 5);
        checkOutput("readp nowb data", rd, 32'h44);
        checkOutput("readp nowb ptr", rp, 32'h30);
        checkOutput("readp nowb access count", log_addr.size(), 2);

        // Pointer FFFFFFFF: address wraps to 0xFF, increment wraps to 0.
        mem[32'h10A] = 32'hFFFFFFFF;
        mem[32'hFF]  = 32'h99;
        applyStimulus(0, 2'b01, 4'd10, 2'b01, 32'h0, 32'h100, lat, rd, rp);
        checkOutput("wrap data", rd, 32'h99);
        expectAccess("wrap acc1", 1, 1'b0, 32'hFF, 32'h0);
        expectAccess("wrap acc2", 2, 1'b1, 32'h10A, 32'h0);

        // Delayed ack: command held stable, one transaction only.
        ack_delay = 5;
        unstable_cnt = 0;
        applyStimulus(2, 2'b00, 4'd3, 2'b00, 32'h0, 32'h100, lat, rd, rp);
        checkOutput("slow latency", lat, 8);
        checkOutput("slow data", rd, 32'hDEAD);
        checkOutput("slow access count", log_addr.size(), 1);
        checkOutput("slow bus stability", unstable_cnt, 0);
        ack_delay = 0;

        // Round-robin from a fresh reset with all channels requesting.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.base_addr = 32'h300;
        bus.req_op    = '0;
        bus.req_reg   = '0;
        bus.req_valid = '1;
        acc = 0;
        n = 0;
        while (acc < 5 && n < 200) begin
            #1;
            if (bus.req_ready != '0) begin
                checkOutput("rr onehot", $countones(bus.req_ready), 1);
                for (int i = 0; i < NCH; i++)
                    if (bus.req_ready[i]) order[acc] = i;
                acc++;
            end
            @(negedge clk);
            n++;
        end
        bus.req_valid = '0;
        checkOutput("rr accepts", acc, 5);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("rr order %0d", i), order[i], i % NCH);
        repeat (6) @(negedge clk);

        // Reset while RD_IND of a READ_P is waiting for its ack.
        ack_delay = 3;
        mem[32'h121] = 32'h55;
        mem[32'h105] = 32'h21;
        log_we.delete();
        log_addr.delete();
        log_wdata.delete();
        bus.req_op[3:2]    = 2'b01;
        bus.req_reg[7:4]   = 4'd5;
        bus.req_flags[3:2] = 2'b01;
        bus.base_addr      = 32'h100;
        bus.req_valid[1]   = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[1] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        n = 0;
        while (!(bus.mem_req && bus.mem_addr == 32'h121) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rd_ind reached", n < 50, 1'b1);
        rst = 1'b1;
        stray_ack = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midreset mem_req", bus.mem_req, 0);
        checkOutput("midreset rsp_valid", bus.rsp_valid, 0);
        checkOutput("midreset req_ready", bus.req_ready, 0);
        checkOutput("midreset rsp_data", bus.rsp_data, 0);
        checkOutput("midreset rsp_ptr", bus.rsp_ptr, 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) stray_ack = 1'b0;
            #1;
            if (bus.rsp_valid != '0 || bus.mem_req) bad++;
        end
        checkOutput("post-reset quiet", bad, 0);
        checkOutput("post-reset rsp_data", bus.rsp_data, 0);
        checkOutput("post-reset access count", log_addr.size(), 1);
        checkOutput("post-reset no wb", memRead(32'h105), 32'h21);
        ack_delay = 0;
        applyStimulus(0, 2'b00, 4'd3, 2'b00, 32'h0, 32'h100, lat, rd, rp);
        checkOutput("after reset latency", lat, 3);
        checkOutput("after reset data", rd, 32'hDEAD);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
